// File: rtl/pipeline_control_pkg.sv
// Shared types for the pipeline hazard/flow controller.
// IM_HALT is only present when PIPELINE_INVALID_INS_HALT_EN is defined.
package pipeline_control_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IM_IDLE  = 2'd0,
    IM_FETCH = 2'd1
`ifdef PIPELINE_INVALID_INS_HALT_EN
    ,
    IM_HALT  = 2'd2
`endif
  } ins_mem_state_t;

endpackage

// File: rtl/pipeline_fetch_fsm.sv
// Instruction-memory state machine: one flush cycle after reset, then fetch.
// With PIPELINE_INVALID_INS_HALT_EN, an unstalled illegal instruction parks it in IM_HALT.
module pipeline_fetch_fsm
  import pipeline_control_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
`ifdef PIPELINE_INVALID_INS_HALT_EN
  input  logic           i_halt_req,
`endif
  output ins_mem_state_t o_state
);

  ins_mem_state_t r_state;
  ins_mem_state_t w_state_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IM_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IM_IDLE:  w_state_next = IM_FETCH;
      IM_FETCH: begin
`ifdef PIPELINE_INVALID_INS_HALT_EN
        if (i_halt_req) w_state_next = IM_HALT;
`endif
      end
`ifdef PIPELINE_INVALID_INS_HALT_EN
      IM_HALT:  w_state_next = IM_HALT;
`endif
      default:  w_state_next = IM_IDLE;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/pipeline_control.sv
// Hazard and flow controller: per-stage load enables and flushes plus the fetch request.
// Optional halt-on-illegal-instruction behaviour via PIPELINE_INVALID_INS_HALT_EN.
module pipeline_control
  import pipeline_control_pkg::*;
(
  input  logic pipeline_clock_in,
  input  logic pipeline_reset_in,
  input  logic pipeline_bru_correction_flag_in,
  input  logic pipeline_check_correction_flag_in,
  input  logic pipeline_ins_mem_ready_in,
  output logic pipeline_ins_mem_valid_out,
  input  logic pipeline_data_mem_valid_in,
  input  logic pipeline_data_mem_ready_in,
  input  logic pipeline_invalid_ins_in,
  output logic pipeline_pc_if_set_out,
  output logic pipeline_if_dec_set_out,
  output logic pipeline_dec_reg_set_out,
  output logic pipeline_reg_ex_set_out,
  output logic pipeline_ex_wb_set_out,
  output logic pipeline_pc_if_clear_out,
  output logic pipeline_if_dec_clear_out,
  output logic pipeline_dec_reg_clear_out,
  output logic pipeline_reg_ex_clear_out,
  output logic pipeline_ex_wb_clear_out
);

  ins_mem_state_t w_state;
  logic           w_mem_stall;
  logic           w_fetch_ok;

  assign w_mem_stall = pipeline_data_mem_valid_in & ~pipeline_data_mem_ready_in;
  assign w_fetch_ok  = pipeline_ins_mem_ready_in;

`ifdef PIPELINE_INVALID_INS_HALT_EN
  logic w_halt_req;
  assign w_halt_req = pipeline_invalid_ins_in & ~w_mem_stall;
`endif

  pipeline_fetch_fsm u_fetch_fsm (
    .i_clk      (pipeline_clock_in),
    .i_rst_n    (pipeline_reset_in),
`ifdef PIPELINE_INVALID_INS_HALT_EN
    .i_halt_req (w_halt_req),
`endif
    .o_state    (w_state)
  );

  // Defaults are the reset/idle pattern: no loads, flush everything.
  always_comb begin
    pipeline_ins_mem_valid_out = 1'b0;
    pipeline_pc_if_set_out     = 1'b0;
    pipeline_if_dec_set_out    = 1'b0;
    pipeline_dec_reg_set_out   = 1'b0;
    pipeline_reg_ex_set_out    = 1'b0;
    pipeline_ex_wb_set_out     = 1'b0;
    pipeline_pc_if_clear_out   = 1'b1;
    pipeline_if_dec_clear_out  = 1'b1;
    pipeline_dec_reg_clear_out = 1'b1;
    pipeline_reg_ex_clear_out  = 1'b1;
    pipeline_ex_wb_clear_out   = 1'b1;

    if (pipeline_reset_in) begin
      case (w_state)
        IM_FETCH: begin
          pipeline_pc_if_clear_out = 1'b0;
          if (w_mem_stall) begin
            // Freeze every stage; only WB receives a bubble.
            pipeline_if_dec_clear_out  = 1'b0;
            pipeline_dec_reg_clear_out = 1'b0;
            pipeline_reg_ex_clear_out  = 1'b0;
            pipeline_ex_wb_clear_out   = 1'b1;
          end else begin
            pipeline_ins_mem_valid_out = 1'b1;
            pipeline_pc_if_set_out     = w_fetch_ok | pipeline_bru_correction_flag_in
                                         | pipeline_check_correction_flag_in;
            pipeline_if_dec_set_out    = 1'b1;
            pipeline_dec_reg_set_out   = 1'b1;
            pipeline_reg_ex_set_out    = 1'b1;
            pipeline_ex_wb_set_out     = 1'b1;
            pipeline_if_dec_clear_out  = pipeline_bru_correction_flag_in
                                         | pipeline_check_correction_flag_in | ~w_fetch_ok;
            pipeline_dec_reg_clear_out = pipeline_bru_correction_flag_in | pipeline_invalid_ins_in;
            pipeline_reg_ex_clear_out  = pipeline_bru_correction_flag_in;
            pipeline_ex_wb_clear_out   = 1'b0;
          end
        end
`ifdef PIPELINE_INVALID_INS_HALT_EN
        IM_HALT: begin
          pipeline_pc_if_clear_out = 1'b0;
          pipeline_ex_wb_clear_out = 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control; expectations follow PIPELINE_INVALID_INS_HALT_EN.
module tb_pipeline_control;

  logic clk;
  logic rst_n;
  logic bru;
  logic chk;
  logic im_ready;
  logic im_valid;
  logic dm_valid;
  logic dm_ready;
  logic inv;
  logic s_pc_if, s_if_dec, s_dec_reg, s_reg_ex, s_ex_wb;
  logic c_pc_if, c_if_dec, c_dec_reg, c_reg_ex, c_ex_wb;
  logic [10:0] obs;

  int n_checks;
  int n_errors;

  pipeline_control dut (
    .pipeline_clock_in                 (clk),
    .pipeline_reset_in                 (rst_n),
    .pipeline_bru_correction_flag_in   (bru),
    .pipeline_check_correction_flag_in (chk),
    .pipeline_ins_mem_ready_in         (im_ready),
    .pipeline_ins_mem_valid_out        (im_valid),
    .pipeline_data_mem_valid_in        (dm_valid),
    .pipeline_data_mem_ready_in        (dm_ready),
    .pipeline_invalid_ins_in           (inv),
    .pipeline_pc_if_set_out            (s_pc_if),
    .pipeline_if_dec_set_out           (s_if_dec),
    .pipeline_dec_reg_set_out          (s_dec_reg),
    .pipeline_reg_ex_set_out           (s_reg_ex),
    .pipeline_ex_wb_set_out            (s_ex_wb),
    .pipeline_pc_if_clear_out          (c_pc_if),
    .pipeline_if_dec_clear_out         (c_if_dec),
    .pipeline_dec_reg_clear_out        (c_dec_reg),
    .pipeline_reg_ex_clear_out         (c_reg_ex),
    .pipeline_ex_wb_clear_out          (c_ex_wb)
  );

  // {valid, sets pc_if..ex_wb, clears pc_if..ex_wb}
  assign obs = {im_valid, s_pc_if, s_if_dec, s_dec_reg, s_reg_ex, s_ex_wb,
                c_pc_if, c_if_dec, c_dec_reg, c_reg_ex, c_ex_wb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b_%b_%b expected %b_%b_%b", tag,
               got[10], got[9:5], got[4:0], exp[10], exp[9:5], exp[4:0]);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then sample before the next edge.
  task automatic apply(input logic b, input logic c, input logic imr,
                       input logic dmv, input logic dmr, input logic iv,
                       input string tag, input logic [10:0] exp);
    @(posedge clk);
    #1;
    bru = b; chk = c; im_ready = imr; dm_valid = dmv; dm_ready = dmr; inv = iv;
    #2;
    check_eq(tag, obs, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bru = 1'b0; chk = 1'b0; im_ready = 1'b0; dm_valid = 1'b0; dm_ready = 1'b0; inv = 1'b0;

    #2;
    check_eq("reset_held", obs, 11'b0_00000_11111);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("idle_after_release", obs, 11'b0_00000_11111);

    //      bru chk imr dmv dmr inv
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "fetch_ready",       11'b1_11111_00000);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "fetch_not_ready",   11'b1_01111_01000);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "stall_masks_bru",   11'b0_00000_00001);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "stall_end_bru",     11'b1_11111_01110);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "check_not_ready",   11'b1_11111_01000);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "bru_not_ready",     11'b1_11111_01110);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "dmem_done_nostall", 11'b1_11111_00000);
    apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "stall_masks_all",   11'b0_00000_00001);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "bru_and_check",     11'b1_11111_01110);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "invalid_ins",       11'b1_11111_00100);
`ifdef PIPELINE_INVALID_INS_HALT_EN
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "halt_entered",      11'b0_00000_01110);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "halt_holds",        11'b0_00000_01110);
`else
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "after_invalid",     11'b1_11111_00000);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "no_halt",           11'b1_11111_01110);
`endif

    // Reset mid-operation forces the flush pattern without waiting for an edge.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("reset_midop", obs, 11'b0_00000_11111);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("idle_after_rerelease", obs, 11'b0_00000_11111);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "fetch_after_reset", 11'b1_11111_00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
